sparc_exu_alu_arb: RTL and testbench

- Arbitrates the shared EXU ALU between two requesters.
  - Requester 0 is the issue pipe and has priority.
  - Requester 1 is an auxiliary address/logic client, e.g. the MMU/LSU address generator.
- Registers the winning op into one-hot, active-low ALU output selects plus active-high logic selects, cin and invert.
- Captures the ALU result one cycle later and returns it to the winner with its tag.
- Includes an anti-starvation counter for requester 1 and a pipeline hold input.

---
 rtl/sparc_exu_alu_arb_pkg.sv | 41 ++++
 rtl/sparc_exu_alu_arb_alu_op_dec.sv | 41 ++++
 rtl/sparc_exu_alu_arb.sv | 162 ++++++++++++++++
 tb/tb_sparc_exu_alu_arb.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_exu_alu_arb_pkg.sv
// Shared definitions for the EXU ALU arbiter: op encodings, decoded-control
// bit positions and the decoded-control payload.
package sparc_exu_alu_arb_pkg;

  localparam int unsigned TAGW_DEF = 2;
  localparam int unsigned OP_W     = 3;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned STARVE_W = 4;

  typedef enum logic [OP_W-1:0] {
    ALU_OP_ADD   = 3'd0,
    ALU_OP_SUB   = 3'd1,
    ALU_OP_AND   = 3'd2,
    ALU_OP_OR    = 3'd3,
    ALU_OP_XOR   = 3'd4,
    ALU_OP_MOVE  = 3'd5,
    ALU_OP_SHIFT = 3'd6,
    ALU_OP_RS3   = 3'd7
  } alu_op_e;

  // Output-select bit positions (active-high inside the decoder)
  localparam int unsigned OSEL_SUM   = 0;
  localparam int unsigned OSEL_RS3   = 1;
  localparam int unsigned OSEL_SHIFT = 2;
  localparam int unsigned OSEL_LOGIC = 3;

  // Logic-unit select bit positions
  localparam int unsigned LSEL_AND  = 0;
  localparam int unsigned LSEL_OR   = 1;
  localparam int unsigned LSEL_XOR  = 2;
  localparam int unsigned LSEL_MOVE = 3;

  typedef struct packed {
    logic [SEL_W-1:0] out_sel;
    logic [SEL_W-1:0] log_sel;
    logic             cin;
    logic             invert;
  } alu_ctl_t;

endpackage

// File: rtl/sparc_exu_alu_arb_alu_op_dec.sv
// Combinational op decoder: ALU op to one-hot output select, logic select,
// carry-in and operand invert. Shared with the ECL.
module sparc_exu_alu_arb_alu_op_dec
  import sparc_exu_alu_arb_pkg::*;
(
  input  logic [OP_W-1:0] op,
  output alu_ctl_t        ctl_c
);

  always_comb begin
    ctl_c = '0;
    case (alu_op_e'(op))
      ALU_OP_ADD:   ctl_c.out_sel[OSEL_SUM] = 1'b1;
      ALU_OP_SUB: begin
        ctl_c.out_sel[OSEL_SUM] = 1'b1;
        ctl_c.cin               = 1'b1;
        ctl_c.invert            = 1'b1;
      end
      ALU_OP_AND: begin
        ctl_c.out_sel[OSEL_LOGIC] = 1'b1;
        ctl_c.log_sel[LSEL_AND]   = 1'b1;
      end
      ALU_OP_OR: begin
        ctl_c.out_sel[OSEL_LOGIC] = 1'b1;
        ctl_c.log_sel[LSEL_OR]    = 1'b1;
      end
      ALU_OP_XOR: begin
        ctl_c.out_sel[OSEL_LOGIC] = 1'b1;
        ctl_c.log_sel[LSEL_XOR]   = 1'b1;
      end
      ALU_OP_MOVE: begin
        ctl_c.out_sel[OSEL_LOGIC] = 1'b1;
        ctl_c.log_sel[LSEL_MOVE]  = 1'b1;
      end
      ALU_OP_SHIFT: ctl_c.out_sel[OSEL_SHIFT] = 1'b1;
      ALU_OP_RS3:   ctl_c.out_sel[OSEL_RS3]   = 1'b1;
      default:      ctl_c = '0;
    endcase
  end

endmodule

// File: rtl/sparc_exu_alu_arb.sv
// Two-requester arbiter for the shared EXU ALU: A-stage grant, registered
// E-stage controls, and an R-stage response carrying the winner's tag.
module sparc_exu_alu_arb
  import sparc_exu_alu_arb_pkg::*;
#(
  parameter int unsigned TAGW       = TAGW_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              rclk,
  input  logic              arst_l,
  input  logic              req0_vld,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [TAGW-1:0]   req0_tag,
  output logic              req0_rdy,
  input  logic              req1_vld,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [TAGW-1:0]   req1_tag,
  output logic              req1_rdy,
  input  logic              hold_e,
  input  logic [DATA_W-1:0] alu_rd_data_e,
  output logic              ctl_out_sel_sum_e_l,
  output logic              ctl_out_sel_rs3_e_l,
  output logic              ctl_out_sel_shift_e_l,
  output logic              ctl_out_sel_logic_e_l,
  output logic              ctl_log_sel_and_e,
  output logic              ctl_log_sel_or_e,
  output logic              ctl_log_sel_xor_e,
  output logic              ctl_log_sel_move_e,
  output logic              ctl_cin_e,
  output logic              ctl_invert_d,
  output logic              rsp_vld,
  output logic              rsp_id,
  output logic [TAGW-1:0]   rsp_tag,
  output logic [DATA_W-1:0] rsp_data
);

  if (STARVE_MAX == 0 || STARVE_MAX > (2**STARVE_W) - 1) begin : g_bad_starve_max
    $error("sparc_exu_alu_arb: STARVE_MAX must be in 1..15");
  end

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  logic                starve_cnt_q, starve_unused;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                e_vld_q, e_vld_d;
  logic [SEL_W-1:0]    e_out_sel_l_q, e_out_sel_l_d;
  logic [SEL_W-1:0]    e_log_sel_q, e_log_sel_d;
  logic                e_cin_q, e_cin_d;
  logic                e_id_q, e_id_d;
  logic [TAGW-1:0]     e_tag_q, e_tag_d;
  logic                rsp_vld_q, rsp_vld_d;
  logic                rsp_id_q, rsp_id_d;
  logic [TAGW-1:0]     rsp_tag_q, rsp_tag_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;

  logic                starve_hit_c, gnt0_c, gnt1_c, gnt_c;
  logic [OP_W-1:0]     gnt_op_c;
  logic [TAGW-1:0]     gnt_tag_c;
  alu_ctl_t            dec_c;

  assign starve_cnt_q  = 1'b0;
  assign starve_unused = starve_cnt_q;

  // A stage: a starved requester 1 beats requester 0; hold_e blocks every grant
  always_comb begin
    starve_hit_c = (starve_q == STARVE_LIM) && req1_vld;
    gnt0_c       = !hold_e && req0_vld && !starve_hit_c;
    gnt1_c       = !hold_e && req1_vld && (starve_hit_c || !req0_vld);
    gnt_c        = gnt0_c || gnt1_c;
    gnt_op_c     = gnt1_c ? req1_op  : req0_op;
    gnt_tag_c    = gnt1_c ? req1_tag : req0_tag;
  end

  sparc_exu_alu_arb_alu_op_dec u_dec (
    .op    (gnt_op_c),
    .ctl_c (dec_c)
  );

  assign req0_rdy     = gnt0_c;
  assign req1_rdy     = gnt1_c;
  assign ctl_invert_d = gnt_c && dec_c.invert;

  always_comb begin
    starve_d      = starve_q;
    e_vld_d       = e_vld_q;
    e_out_sel_l_d = e_out_sel_l_q;
    e_log_sel_d   = e_log_sel_q;
    e_cin_d       = e_cin_q;
    e_id_d        = e_id_q;
    e_tag_d       = e_tag_q;
    rsp_vld_d     = 1'b0;
    rsp_id_d      = rsp_id_q;
    rsp_tag_d     = rsp_tag_q;
    rsp_data_d    = rsp_data_q;

    if (!hold_e) begin
      if (req1_vld && gnt0_c) begin
        if (starve_q != STARVE_LIM) starve_d = starve_q + STARVE_W'(1);
      end else begin
        starve_d = '0;
      end

      // An empty E stage drives every output select inactive
      e_vld_d       = gnt_c;
      e_out_sel_l_d = gnt_c ? ~dec_c.out_sel : '1;
      e_log_sel_d   = gnt_c ? dec_c.log_sel  : '0;
      e_cin_d       = gnt_c && dec_c.cin;
      e_id_d        = gnt1_c;
      e_tag_d       = gnt_c ? gnt_tag_c : e_tag_q;

      if (e_vld_q) begin
        rsp_vld_d  = 1'b1;
        rsp_id_d   = e_id_q;
        rsp_tag_d  = e_tag_q;
        rsp_data_d = alu_rd_data_e;
      end
    end
  end

  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      starve_q      <= '0;
      e_vld_q       <= 1'b0;
      e_out_sel_l_q <= '1;
      e_log_sel_q   <= '0;
      e_cin_q       <= 1'b0;
      e_id_q        <= 1'b0;
      e_tag_q       <= '0;
      rsp_vld_q     <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_tag_q     <= '0;
      rsp_data_q    <= '0;
    end else begin
      starve_q      <= starve_d;
      e_vld_q       <= e_vld_d;
      e_out_sel_l_q <= e_out_sel_l_d;
      e_log_sel_q   <= e_log_sel_d;
      e_cin_q       <= e_cin_d;
      e_id_q        <= e_id_d;
      e_tag_q       <= e_tag_d;
      rsp_vld_q     <= rsp_vld_d;
      rsp_id_q      <= rsp_id_d;
      rsp_tag_q     <= rsp_tag_d;
      rsp_data_q    <= rsp_data_d;
    end
  end

  assign ctl_out_sel_sum_e_l   = e_out_sel_l_q[OSEL_SUM];
  assign ctl_out_sel_rs3_e_l   = e_out_sel_l_q[OSEL_RS3];
  assign ctl_out_sel_shift_e_l = e_out_sel_l_q[OSEL_SHIFT];
  assign ctl_out_sel_logic_e_l = e_out_sel_l_q[OSEL_LOGIC];
  assign ctl_log_sel_and_e     = e_log_sel_q[LSEL_AND];
  assign ctl_log_sel_or_e      = e_log_sel_q[LSEL_OR];
  assign ctl_log_sel_xor_e     = e_log_sel_q[LSEL_XOR];
  assign ctl_log_sel_move_e    = e_log_sel_q[LSEL_MOVE];
  assign ctl_cin_e             = e_cin_q;
  assign rsp_vld               = rsp_vld_q;
  assign rsp_id                = rsp_id_q;
  assign rsp_tag               = rsp_tag_q;
  assign rsp_data              = rsp_data_q;

endmodule

// File: tb/tb_sparc_exu_alu_arb.sv
// Directed self-checking bench for sparc_exu_alu_arb (TAGW=2, STARVE_MAX=4).
module tb_sparc_exu_alu_arb;

  logic        rclk;
  logic        arst_l;
  logic        req0_vld, req1_vld, hold_e;
  logic [2:0]  req0_op, req1_op;
  logic [1:0]  req0_tag, req1_tag;
  logic        req0_rdy, req1_rdy;
  logic [63:0] alu_rd_data_e;
  logic        sum_l, rs3_l, shift_l, logic_l;
  logic        l_and, l_or, l_xor, l_move;
  logic        cin_e, invert_d;
  logic        rsp_vld, rsp_id;
  logic [1:0]  rsp_tag;
  logic [63:0] rsp_data;

  int n_cmp = 0;
  int n_err = 0;

  // Expected E-stage controls per op: sel = {sum,rs3,shift,logic}_l, log = {and,or,xor,move}
  logic [3:0] exp_sel [8] = '{4'b0111, 4'b0111, 4'b1110, 4'b1110,
                              4'b1110, 4'b1110, 4'b1101, 4'b1011};
  logic [3:0] exp_log [8] = '{4'b0000, 4'b0000, 4'b1000, 4'b0100,
                              4'b0010, 4'b0001, 4'b0000, 4'b0000};
  logic       exp_cin [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       exp_gnt [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  sparc_exu_alu_arb #(.TAGW(2), .STARVE_MAX(4)) dut (
    .rclk                  (rclk),
    .arst_l                (arst_l),
    .req0_vld              (req0_vld),
    .req0_op               (req0_op),
    .req0_tag              (req0_tag),
    .req0_rdy              (req0_rdy),
    .req1_vld              (req1_vld),
    .req1_op               (req1_op),
    .req1_tag              (req1_tag),
    .req1_rdy              (req1_rdy),
    .hold_e                (hold_e),
    .alu_rd_data_e         (alu_rd_data_e),
    .ctl_out_sel_sum_e_l   (sum_l),
    .ctl_out_sel_rs3_e_l   (rs3_l),
    .ctl_out_sel_shift_e_l (shift_l),
    .ctl_out_sel_logic_e_l (logic_l),
    .ctl_log_sel_and_e     (l_and),
    .ctl_log_sel_or_e      (l_or),
    .ctl_log_sel_xor_e     (l_xor),
    .ctl_log_sel_move_e    (l_move),
    .ctl_cin_e             (cin_e),
    .ctl_invert_d          (invert_d),
    .rsp_vld               (rsp_vld),
    .rsp_id                (rsp_id),
    .rsp_tag               (rsp_tag),
    .rsp_data              (rsp_data)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_e(input string tag, input logic [3:0] sel, input logic [3:0] lg,
                       input logic cin);
    chk({tag, "_sel"}, 64'({sum_l, rs3_l, shift_l, logic_l}), 64'(sel));
    chk({tag, "_log"}, 64'({l_and, l_or, l_xor, l_move}), 64'(lg));
    chk({tag, "_cin"}, 64'(cin_e), 64'(cin));
  endtask

  task automatic chk_rsp(input string tag, input logic vld, input logic id,
                         input logic [1:0] t, input logic [63:0] d);
    chk({tag, "_vld"}, 64'(rsp_vld), 64'(vld));
    if (vld) begin
      chk({tag, "_id"}, 64'(rsp_id), 64'(id));
      chk({tag, "_tag"}, 64'(rsp_tag), 64'(t));
      chk({tag, "_data"}, rsp_data, d);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  initial begin
    req0_vld = 0; req0_op = 0; req0_tag = 0;
    req1_vld = 0; req1_op = 0; req1_tag = 0;
    hold_e = 0; alu_rd_data_e = '0;
    arst_l = 1'b1;
    #2 arst_l = 1'b0;

    // Reset values
    tick(); tick();
    chk_e("rst_e", 4'b1111, 4'b0000, 1'b0);
    chk("rst_rsp_vld", 64'(rsp_vld), 64'd0);
    chk("rst_rsp_id", 64'(rsp_id), 64'd0);
    chk("rst_rsp_tag", 64'(rsp_tag), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rdy", 64'({req0_rdy, req1_rdy}), 64'd0);
    chk("rst_inv", 64'(invert_d), 64'd0);
    arst_l = 1'b1;

    // Single SUB from requester 1
    tick();
    req1_vld = 1; req1_op = 3'd1; req1_tag = 2'b10;
    #1;
    chk("sub_rdy", 64'({req0_rdy, req1_rdy}), 64'b01);
    chk("sub_inv_d", 64'(invert_d), 64'd1);
    tick();
    chk_e("sub_e", 4'b0111, 4'b0000, 1'b1);
    chk("sub_rsp_early", 64'(rsp_vld), 64'd0);
    req1_vld = 0;
    alu_rd_data_e = 64'hDEAD_BEEF_0123_4567;
    #1;
    chk("sub_inv_idle", 64'(invert_d), 64'd0);
    tick();
    chk_rsp("sub_rsp", 1'b1, 1'b1, 2'b10, 64'hDEAD_BEEF_0123_4567);
    chk_e("sub_e_idle", 4'b1111, 4'b0000, 1'b0);
    alu_rd_data_e = 64'h0;
    tick();
    chk("sub_rsp_drop", 64'(rsp_vld), 64'd0);
    chk("sub_data_hold", rsp_data, 64'hDEAD_BEEF_0123_4567);

    // Decode sweep, ops 0..7 back to back from requester 0
    for (int i = 0; i < 11; i++) begin
      tick();
      if (i >= 1 && i <= 8) chk_e("sweep_e", exp_sel[i-1], exp_log[i-1], exp_cin[i-1]);
      else chk_e("sweep_idle", 4'b1111, 4'b0000, 1'b0);
      if (i >= 2 && i <= 9)
        chk_rsp("sweep_rsp", 1'b1, 1'b0, 2'(i-2), 64'hA5A5_0000_0000_0000 | 64'(i-1));
      else chk_rsp("sweep_rsp", 1'b0, 1'b0, 2'b00, 64'h0);
      alu_rd_data_e = 64'hA5A5_0000_0000_0000 | 64'(i);
      req0_vld = (i < 8);
      req0_op  = 3'(i);
      req0_tag = 2'(i);
      #1;
      if (i < 8) begin
        chk("sweep_rdy", 64'({req0_rdy, req1_rdy}), 64'b10);
        chk("sweep_inv_d", 64'(invert_d), 64'(i == 1));
      end
    end

    // Both requesters continuously valid: grants 0,0,0,0,1 repeating
    req0_op = 3'd0; req0_tag = 2'b01;
    req1_op = 3'd1; req1_tag = 2'b10;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (i >= 2 && i <= 11)
        chk_rsp("starve_rsp", 1'b1, exp_gnt[i-2], exp_gnt[i-2] ? 2'b10 : 2'b01,
                64'hC000 | 64'(i-1));
      else chk_rsp("starve_rsp", 1'b0, 1'b0, 2'b00, 64'h0);
      alu_rd_data_e = 64'hC000 | 64'(i);
      req0_vld = (i < 10);
      req1_vld = (i < 10);
      #1;
      if (i < 10) begin
        chk("starve_rdy", 64'({req0_rdy, req1_rdy}),
            exp_gnt[i] ? 64'b01 : 64'b10);
        chk("starve_inv_d", 64'(invert_d), 64'(exp_gnt[i]));
      end
    end

    // hold_e for three cycles with XOR in E
    tick();
    req0_vld = 1; req0_op = 3'd0; req0_tag = 2'd0; alu_rd_data_e = 64'h1;
    #1 chk("hold_rdy_c0", 64'(req0_rdy), 64'd1);
    tick();
    chk_e("hold_add_e", 4'b0111, 4'b0000, 1'b0);
    req0_op = 3'd4; req0_tag = 2'd1; alu_rd_data_e = 64'h1111;
    #1 chk("hold_rdy_c1", 64'(req0_rdy), 64'd1);
    tick();
    chk_e("hold_xor_e", 4'b1110, 4'b0010, 1'b0);
    chk_rsp("hold_pre_rsp", 1'b1, 1'b0, 2'd0, 64'h1111);
    hold_e = 1; req0_op = 3'd2; req0_tag = 2'd2; alu_rd_data_e = 64'h2222;
    #1;
    chk("hold_rdy_c2", 64'({req0_rdy, req1_rdy}), 64'd0);
    chk("hold_inv_c2", 64'(invert_d), 64'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_e("hold_frozen_e", 4'b1110, 4'b0010, 1'b0);
      chk("hold_rsp_vld", 64'(rsp_vld), 64'd0);
      chk("hold_rsp_data", rsp_data, 64'h1111);
      alu_rd_data_e = 64'h3333;
      #1 chk("hold_rdy", 64'({req0_rdy, req1_rdy}), 64'd0);
    end
    tick();
    chk_e("hold_rel_e", 4'b1110, 4'b0010, 1'b0);
    chk("hold_rel_rsp", 64'(rsp_vld), 64'd0);
    hold_e = 0; alu_rd_data_e = 64'h5555;
    #1 chk("hold_rel_rdy", 64'({req0_rdy, req1_rdy}), 64'b10);
    tick();
    chk_e("hold_and_e", 4'b1110, 4'b1000, 1'b0);
    chk_rsp("hold_xor_rsp", 1'b1, 1'b0, 2'd1, 64'h5555);
    req0_vld = 0; alu_rd_data_e = 64'h6666;
    tick();
    chk_e("hold_idle_e", 4'b1111, 4'b0000, 1'b0);
    chk_rsp("hold_and_rsp", 1'b1, 1'b0, 2'd2, 64'h6666);
    tick();
    chk("hold_done", 64'(rsp_vld), 64'd0);

    // Reset asserted with ops in E and R
    tick();
    req1_vld = 1; req1_op = 3'd7; req1_tag = 2'd3;
    tick();
    req1_vld = 0; req0_vld = 1; req0_op = 3'd6; req0_tag = 2'd1;
    alu_rd_data_e = 64'h7777;
    tick();
    chk_e("mid_shift_e", 4'b1101, 4'b0000, 1'b0);
    chk_rsp("mid_rs3_rsp", 1'b1, 1'b1, 2'd3, 64'h7777);
    req0_vld = 0;
    #2 arst_l = 1'b0;
    #1;
    chk_e("mid_rst_e", 4'b1111, 4'b0000, 1'b0);
    chk("mid_rst_vld", 64'(rsp_vld), 64'd0);
    chk("mid_rst_data", rsp_data, 64'd0);
    chk("mid_rst_tag", 64'(rsp_tag), 64'd0);
    tick(); tick();
    arst_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_vld", 64'(rsp_vld), 64'd0);
      chk("post_rst_sel", 64'({sum_l, rs3_l, shift_l, logic_l}), 64'hF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
